// File: rtl/demux4_reg_pkg.sv
// Shared definitions for the registered 1-to-4 output demultiplexer.
//   N_CH          : number of output channels
//   CH0..CH3      : SEL encodings for each channel
//   chan_state_e  : per-channel holding-register state
package demux4_reg_pkg;

  localparam int N_CH = 4;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/demux4_reg_chan.sv
// One demux channel: holding register, valid flag and sticky overrun flag.
//   CLK      in   system clock
//   RST      in   synchronous active-high reset
//   wr       in   write strobe already qualified by the channel select
//   IN       in   data word to load
//   ack      in   consumer acknowledge
//   ovr_clr  in   clear the overrun flag
//   data     out  holding register
//   valid    out  holding register contains an unconsumed word
//   ovr      out  sticky: a write to this channel was dropped
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | no unconsumed word; any write is accepted
// ST_FULL  | word held; write accepted only with ack
module demux_chan_reg
  import demux4_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic                  ack,
  input  logic                  ovr_clr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  ovr
);

  chan_state_e           r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ovr;
  logic                  w_drop;

  // A write only drops when the held word is not consumed in the same cycle.
  assign w_drop = wr & (r_state == ST_FULL) & ~ack;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (wr) begin
            r_data  <= IN;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (wr && ack) begin
            r_data <= IN;
          end else if (!wr && ack) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      // Set wins over clear so a drop coincident with a clear is not lost.
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign data  = r_data;
  assign valid = (r_state == ST_FULL);
  assign ovr   = r_ovr;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 output demultiplexer with per-channel valid/ack
// handshake and sticky overrun flags.
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   IN         in   data word to store
//   SEL        in   destination channel
//   WE         in   write strobe
//   ACK        in   per-channel consumer acknowledge
//   OVR_CLR    in   clear all overrun flags
//   WREADY     out  selected channel can accept a write (combinational)
//   OUT0..OUT3 out  channel holding registers
//   VALID      out  per-channel unconsumed-word flags
//   OVR        out  per-channel sticky overrun flags
module demux4_reg
  import demux4_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [1:0]            SEL,
  input  logic                  WE,
  input  logic [N_CH-1:0]       ACK,
  input  logic                  OVR_CLR,
  output logic                  WREADY,
  output logic [DATA_WIDTH-1:0] OUT0,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic [DATA_WIDTH-1:0] OUT3,
  output logic [N_CH-1:0]       VALID,
  output logic [N_CH-1:0]       OVR
);

  logic [N_CH-1:0]       w_wr;
  logic [DATA_WIDTH-1:0] w_data [N_CH];

  assign w_wr[0] = WE & (SEL == CH0);
  assign w_wr[1] = WE & (SEL == CH1);
  assign w_wr[2] = WE & (SEL == CH2);
  assign w_wr[3] = WE & (SEL == CH3);

  // Independent of WE so a producer can test readiness before committing.
  assign WREADY = ~VALID[SEL] | ACK[SEL];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    demux_chan_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_chan (
      .CLK     (CLK),
      .RST     (RST),
      .wr      (w_wr[gi]),
      .IN      (IN),
      .ack     (ACK[gi]),
      .ovr_clr (OVR_CLR),
      .data    (w_data[gi]),
      .valid   (VALID[gi]),
      .ovr     (OVR[gi])
    );
  end

  assign OUT0 = w_data[0];
  assign OUT1 = w_data[1];
  assign OUT2 = w_data[2];
  assign OUT3 = w_data[3];

endmodule

// File: tb/tb_demux4_reg.sv
module tb_demux4_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IN;
  logic [1:0] SEL;
  logic       WE;
  logic [3:0] ACK;
  logic       OVR_CLR;
  logic       WREADY;
  logic [7:0] OUT0, OUT1, OUT2, OUT3;
  logic [3:0] VALID;
  logic [3:0] OVR;

  demux4_reg #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .SEL(SEL), .WE(WE), .ACK(ACK),
    .OVR_CLR(OVR_CLR), .WREADY(WREADY), .OUT0(OUT0), .OUT1(OUT1),
    .OUT2(OUT2), .OUT3(OUT3), .VALID(VALID), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0] m_out [4];
  logic [3:0] m_valid;
  logic [3:0] m_ovr;

  // Scoreboard of expected {OUT3,OUT2,OUT1,OUT0,VALID,OVR} after each edge
  logic [39:0] sb [$];
  logic [39:0] exp_v;

  function automatic logic [39:0] dut_state();
    return {OUT3, OUT2, OUT1, OUT0, VALID, OVR};
  endfunction

  function automatic logic model_wready();
    return ~m_valid[SEL] | ACK[SEL];
  endfunction

  // Apply the current inputs to the model, queue the expectation, clock once.
  task automatic cycle();
    logic wr, drop;
    if (RST) begin
      for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
      m_valid = 4'b0000;
      m_ovr   = 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        wr   = WE && (SEL == k[1:0]);
        drop = wr && m_valid[k] && !ACK[k];
        if (wr && !drop) begin
          m_out[k]   = IN;
          m_valid[k] = 1'b1;
        end else if (!wr && ACK[k] && m_valid[k]) begin
          m_valid[k] = 1'b0;
        end
        if (drop) m_ovr[k] = 1'b1;
        else if (OVR_CLR) m_ovr[k] = 1'b0;
      end
    end
    sb.push_back({m_out[3], m_out[2], m_out[1], m_out[0], m_valid, m_ovr});
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WE = 1'b0; SEL = 2'd0; IN = 8'h00; ACK = 4'b0000; OVR_CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; WE = 1'b1; SEL = 2'd2; IN = 8'hAA; ACK = 4'b0000; OVR_CLR = 1'b0;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v) $display("FAIL reset_sb: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    n_total++;
    if ({OUT0, OUT1, OUT2, OUT3, VALID, OVR} !== 40'h0)
      $display("FAIL reset_zero: got %h want 0", {OUT0, OUT1, OUT2, OUT3, VALID, OVR});
    else n_pass++;
    RST = 1'b0;
    idle_inputs();
  endtask

  task automatic test_routing();
    logic [7:0] vals [4];
    logic [7:0] outs [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      WE = 1'b1; SEL = i[1:0]; IN = vals[i];
      #1;
      n_total++;
      if (WREADY !== 1'b1 || WREADY !== model_wready())
        $display("FAIL route_wready%0d: got %b want 1", i, WREADY);
      else n_pass++;
      cycle();
      exp_v = sb.pop_front();
      outs[0] = OUT0; outs[1] = OUT1; outs[2] = OUT2; outs[3] = OUT3;
      n_total++;
      if (dut_state() !== exp_v || outs[i] !== vals[i])
        $display("FAIL route_ch%0d: got %h want %h", i, dut_state(), exp_v);
      else n_pass++;
    end
    idle_inputs();
    n_total++;
    if (VALID !== 4'b1111 || OVR !== 4'b0000)
      $display("FAIL route_flags: got valid=%b ovr=%b want 1111/0000", VALID, OVR);
    else n_pass++;
  endtask

  task automatic test_overrun();
    WE = 1'b1; SEL = 2'd1; IN = 8'h55; ACK = 4'b0000;
    #1;
    n_total++;
    if (WREADY !== 1'b0) $display("FAIL ovr_wready: got %b want 0", WREADY);
    else n_pass++;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || OUT1 !== 8'h22 || OVR[1] !== 1'b1)
      $display("FAIL ovr_drop: got out1=%h ovr=%b want 22/x1x", OUT1, OVR);
    else n_pass++;
    idle_inputs();
    OVR_CLR = 1'b1;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || OVR !== 4'b0000 || VALID[1] !== 1'b1)
      $display("FAIL ovr_clear: got ovr=%b valid=%b want 0000/xx1x", OVR, VALID);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_ack_write();
    ACK = 4'b0100; WE = 1'b1; SEL = 2'd2; IN = 8'h66;
    #1;
    n_total++;
    if (WREADY !== 1'b1) $display("FAIL ackwr_wready: got %b want 1", WREADY);
    else n_pass++;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || OUT2 !== 8'h66 || VALID[2] !== 1'b1 || OVR[2] !== 1'b0)
      $display("FAIL ackwr: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_ack_priority();
    ACK = 4'b1001;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || VALID[0] !== 1'b0 || VALID[3] !== 1'b0 ||
        OUT0 !== 8'h11 || OUT3 !== 8'h44)
      $display("FAIL ack_multi: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    ACK = 4'b0010;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || VALID[1] !== 1'b0 || OUT1 !== 8'h22)
      $display("FAIL ack_consume1: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || VALID[1] !== 1'b0 || OVR !== 4'b0000)
      $display("FAIL ack_empty: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    idle_inputs();
    WE = 1'b1; SEL = 2'd3; IN = 8'h77;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v) $display("FAIL ack_fill3: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    IN = 8'h88; OVR_CLR = 1'b1;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || OVR[3] !== 1'b1 || OUT3 !== 8'h77)
      $display("FAIL set_over_clr: got ovr=%b out3=%h want 1xxx/77", OVR, OUT3);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      WE = 1'b1; SEL = 2'd0; IN = 8'(i);
      ACK = (i > 1) ? 4'b0001 : 4'b0000;
      cycle();
      exp_v = sb.pop_front();
      n_total++;
      if (dut_state() !== exp_v || OUT0 !== 8'(i) || VALID[0] !== 1'b1 || OVR[0] !== 1'b0)
        $display("FAIL b2b_%0d: got out0=%h valid=%b ovr=%b want %h/xxx1/xxx0",
                 i, OUT0, VALID, OVR, 8'(i));
      else n_pass++;
    end
    idle_inputs();
    ACK = 4'b0001;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v || VALID[0] !== 1'b0 || OUT0 !== 8'h08)
      $display("FAIL b2b_drain: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
    m_valid = 4'b0000;
    m_ovr   = 4'b0000;
    @(posedge CLK);
    #1;
    test_reset();
    test_routing();
    test_overrun();
    test_ack_write();
    test_ack_priority();
    test_back_to_back();
    RST = 1'b1;
    cycle();
    exp_v = sb.pop_front();
    n_total++;
    if (dut_state() !== exp_v) $display("FAIL final_reset: got %h want %h", dut_state(), exp_v);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux4_reg.md
Name: demux4_reg

Overview:
- Registered 1-to-4 output demultiplexer: the write-side counterpart of the 4-to-1 operand select.
- Routes one data word, chosen by SEL, into one of four holding registers that drive the core's output ports / peripheral sinks.
- Each channel has a valid/acknowledge handshake toward its consumer and a sticky overrun flag.
- Sits between the core's write-back path and four output consumers.

Parameters:
DATA_WIDTH, 8, width of the data word and of each channel register

Ports:
CLK  input  1  single system clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-high
IN  input  DATA_WIDTH  data word to store
SEL  input  2  destination channel: 2'b00 -> ch0, 2'b01 -> ch1, 2'b10 -> ch2, 2'b11 -> ch3
WE  input  1  write strobe, one word per cycle
ACK  input  4  per-channel consumer acknowledge; ACK[k] consumes the word held in OUTk
OVR_CLR  input  1  clears all overrun flags
WREADY  output  1  combinational: the selected channel can accept a write this cycle
OUT0  output  DATA_WIDTH  channel 0 holding register
OUT1  output  DATA_WIDTH  channel 1 holding register
OUT2  output  DATA_WIDTH  channel 2 holding register
OUT3  output  DATA_WIDTH  channel 3 holding register
VALID  output  4  VALID[k] = OUTk holds an unconsumed word
OVR  output  4  sticky: a write to channel k was dropped

Behaviour:
- Reset: when RST=1 at a rising edge, OUT0..OUT3 <= 0, VALID <= 4'b0000, OVR <= 4'b0000. RST overrides every other input in that cycle. Reset mid-handshake discards held words with no OVR indication.
- WREADY = ~VALID[SEL] | ACK[SEL]. It is purely combinational and does not depend on WE.
- Write with WE=1, SEL=k and WREADY=1: at the edge OUTk <= IN and VALID[k] <= 1. Latency is one cycle; the word is visible the cycle after the write. Other channels are unchanged.
- Write with WE=1, SEL=k and WREADY=0 (VALID[k]=1, ACK[k]=0): the write is dropped, OUTk is unchanged and OVR[k] <= 1.
- ACK[k]=1 while VALID[k]=1 and no write to k in that cycle: VALID[k] <= 0. OUTk keeps its last value; it is not cleared.
- ACK[k]=1 while VALID[k]=0: ignored.
- ACK[k] and a write to k in the same cycle: the old word is consumed and the new word is loaded. VALID[k] stays 1 and OVR[k] is not set. This allows one word per cycle of throughput per channel.
- ACK on several channels in one cycle is allowed. Each channel acts independently.
- WE=0: SEL and IN are ignored.
- OVR_CLR=1: OVR <= 0, except that a bit set by a drop in the same cycle wins (set has priority over clear).
- Per-channel state is two states, EMPTY (VALID=0) and FULL (VALID=1):
  - EMPTY -> FULL on a write.
  - FULL -> EMPTY on ACK without a write.
  - FULL -> FULL on write+ACK, or on a write without ACK (dropped, OVR set).
- There is no arithmetic. Widths are fixed by DATA_WIDTH, and IN is stored unmodified.

Decomposition:
- Shared header (defines): channel count = 4, channel select encodings CH0..CH3 = 2'd0..2'd3.
- Sub-module demux_chan_reg (DATA_WIDTH): one channel's holding register, valid flag and overrun flag.
  - Inputs: CLK, RST, wr (WE & SEL==k), IN, ack, ovr_clr.
  - Outputs: data, valid, ovr.
  - Instantiated 4x. The top level does only SEL decode, WREADY selection and port wiring.

Test Plan:
- Reset: drive RST=1 for one edge with WE=1, SEL=2, IN=8'hAA -> OUT0..3=8'h00, VALID=4'b0000, OVR=4'b0000; nothing is written.
- Basic routing: write 8'h11/SEL=0, 8'h22/SEL=1, 8'h33/SEL=2, 8'h44/SEL=3 on consecutive cycles, each with WREADY=1 -> each OUTk updates one cycle after its write; VALID=4'b1111 after the fourth edge; OVR=0.
- Overrun: with ch1 holding 8'h22 (VALID[1]=1), check WREADY=0 at SEL=1, then write 8'h55 to ch1 with no ACK -> OUT1 stays 8'h22 and OVR[1]=1. Then OVR_CLR=1 for one cycle -> OVR=0 while VALID[1] stays 1.
- Simultaneous ACK+write: ch2 holds 8'h33; in one cycle ACK[2]=1, WE=1, SEL=2, IN=8'h66 -> OUT2=8'h66, VALID[2]=1, OVR[2]=0.
- Ack behaviour and priority:
  - ACK=4'b1001 -> VALID[0] and VALID[3] clear while OUT0/OUT3 keep 8'h11/8'h44.
  - ACK[1] with VALID[1]=0 -> no change.
  - A drop on ch3 in the same cycle as OVR_CLR=1 -> OVR[3]=1.
- Back-to-back streaming: 8 writes to ch0 with values 1..8 on consecutive cycles, ACK[0] held high from the second cycle -> OUT0 follows 1..8 one cycle late; OVR[0] stays 0; VALID[0]=1 throughout.
